ps2_rx_fifo: RTL

PS/2 keyboard receiver front end: synchronizes the raw `ps2_clk`/`ps2_data` lines, deserializes 11-bit device-to-host frames and checks them, and buffers the received scan-code bytes in a small FIFO. It sits directly upstream of the scan-code analyzer. The analyzer sees `data` and `ready`, and acknowledges with `nextdata_n`.

---
 rtl/ps2_rx_fifo.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo
//
// PS/2 keyboard receiver front end. Synchronizes the raw ps2_clk/ps2_data
// lines, deserializes 11-bit device-to-host frames (start, D0..D7 LSB first,
// odd parity, stop), rejects bad frames, and buffers accepted scan-code bytes
// in a small show-ahead FIFO for the downstream scan-code analyzer.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   : the odd-parity bit is checked; even-parity frames are rejected.
//   undefined : the parity bit is shifted in and ignored (default build).
//
// Parameters
//   FIFO_DEPTH     : FIFO entries, power of 2, >= 2.
//   TIMEOUT_CYCLES : clk cycles without a ps2_clk falling edge, mid-frame,
//                    before the partial frame is dropped.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ps2_clk    in   raw keyboard clock (asynchronous, idles high)
//   ps2_data   in   raw keyboard data (asynchronous, idles high)
//   nextdata_n in   active-low pop request from the consumer
//   data       out  FIFO head byte (show-ahead), 8'h00 when empty
//   ready      out  FIFO not empty
//   overflow   out  sticky: a valid byte was dropped because the FIFO was full
//   frame_err  out  one-cycle pulse on framing/parity error or timeout
// ----------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    // Odd parity over data byte plus parity bit: true when the count of 1s is odd.
    function automatic logic odd_parity9(input logic [8:0] bits);
        return ^bits;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic          s0_q, s1_q, s2_q;
    logic          dat0_q, dat1_q;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shreg_q, shreg_d;     // [0]=start, [8:1]=D0..D7, [9]=parity
    logic [TW-1:0] idle_q, idle_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic       fall_s;
    logic       parity_ok_s;
    logic       frame_ok_s;
    logic       push_req_s;
    logic       pop_s;
    logic       full_s;
    logic       push_s;
    logic       drop_s;
    logic [7:0] wdata_s;

    // Receiver next state: bit shifting, frame evaluation and idle timeout.
    always_comb begin
        fall_s = s2_q & ~s1_q;

`ifdef PS2_PARITY_CHECK_EN
        parity_ok_s = odd_parity9(shreg_q[9:1]);
`else
        // Parity is still computed so the shift-register layout is read the
        // same way in both builds; its result cannot reject a frame here.
        parity_ok_s = odd_parity9(shreg_q[9:1]) | 1'b1;
`endif
        // At the 11th edge the stop bit is the live synchronized data bit.
        frame_ok_s  = ~shreg_q[0] & dat1_q & parity_ok_s;
        wdata_s     = shreg_q[8:1];

        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        idle_d      = idle_q;
        frame_err_d = 1'b0;
        push_req_s  = 1'b0;

        if (fall_s) begin
            idle_d = {TW{1'b0}};
            if (bitcnt_q == LAST_BIT) begin
                bitcnt_d = 4'd0;
                if (frame_ok_s) begin
                    push_req_s = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shreg_d  = {dat1_q, shreg_q[9:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (idle_q == IDLE_LAST) begin
                bitcnt_d    = 4'd0;
                idle_d      = {TW{1'b0}};
                frame_err_d = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1'b1);
            end
        end else begin
            idle_d = {TW{1'b0}};
        end
    end

    // FIFO next state: push/pop arbitration, overflow and show-ahead head.
    always_comb begin
        pop_s  = (count_q != {CW{1'b0}}) & ~nextdata_n;
        full_s = (count_q == FULL_CNT);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_s = push_req_s & (~full_s | pop_s);
        drop_s = push_req_s & full_s & ~pop_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop_s;
        ready_d    = (count_d != {CW{1'b0}});

        // The head may be the byte being written this very edge (slot at
        // wr_ptr_q); otherwise it is already in memory.
        if (count_d == {CW{1'b0}}) begin
            data_d = 8'h00;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            data_d = wdata_s;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
    end

    // State registers with synchronous reset; synchronizers reset to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            dat0_q      <= 1'b1;
            dat1_q      <= 1'b1;
            bitcnt_q    <= 4'd0;
            shreg_q     <= 10'd0;
            idle_q      <= {TW{1'b0}};
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
        end else begin
            s0_q        <= ps2_clk;
            s1_q        <= s0_q;
            s2_q        <= s1_q;
            dat0_q      <= ps2_data;
            dat1_q      <= dat0_q;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            idle_q      <= idle_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
        end
    end

    // FIFO storage; contents are only observable through count-gated reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
